// File: rtl/psevdo_ram_ctrl.sv
// psevdo_ram_ctrl: burst command front-end for a four-bank, 9-bit-wide,
// 256-word pseudo-dual-port RAM. Write bursts stream data in through a
// valid/ready handshake. Read bursts issue one RAM read per cycle, and the
// returned words come back two cycles later on RD_DATA/RD_VALID.
module psevdo_ram_ctrl #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8
) (
  input  logic              CLKS,
  input  logic              RSTB,
  // command channel
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WR,
  input  logic [1:0]        CMD_BANK,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [ADDR_W-1:0] CMD_LEN,
  // write data channel
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  // read data channel (no backpressure)
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              BUSY,
  // RAM side
  output logic [DATA_W-1:0] DIn,
  output logic [ADDR_W-1:0] WADDR,
  output logic [ADDR_W-1:0] RADDR,
  output logic              WRB,
  output logic              RDB,
  output logic              DC_in0,
  output logic              DC_in1,
  output logic              DC_in2,
  input  logic [DATA_W-1:0] DO1,
  input  logic [DATA_W-1:0] DO2
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;    // next address to issue
  logic [ADDR_W-1:0]   rem_q, rem_d;      // words still to issue after the current one
  logic [1:0]          dc_q, dc_d;        // latched bank, drives {DC_in1,DC_in0}
  logic                wrb_q, wrb_d;
  logic                rdb_q, rdb_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;

  // read return pipeline: p0 = RAM access cycle, p1 = captured output
  logic                vld_p0, vld_p1;
  logic                bsel_p0;
  logic [DATA_W-1:0]   rd_data_p1;

  assign CMD_READY = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);
  assign WR_READY  = (state_q == WRITE);

  assign DIn      = din_q;
  assign WADDR    = waddr_q;
  assign RADDR    = raddr_q;
  assign WRB      = wrb_q;
  assign RDB      = rdb_q;
  assign DC_in0   = dc_q[0];
  assign DC_in1   = dc_q[1];
  assign DC_in2   = 1'b0;
  assign RD_DATA  = rd_data_p1;
  assign RD_VALID = vld_p1;

  // Next-state and next RAM-strobe computation; strobes default to inactive.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dc_d    = dc_q;
    wrb_d   = 1'b1;
    rdb_d   = 1'b1;
    din_d   = din_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          dc_d  = CMD_BANK;
          rem_d = CMD_LEN;
          if (CMD_WR) begin
            addr_d  = CMD_ADDR;
            state_d = WRITE;
          end else begin
            // first read word goes out on the accept edge so RDB is low
            // in the very next cycle
            rdb_d   = 1'b0;
            raddr_d = CMD_ADDR;
            addr_d  = CMD_ADDR + 8'd1;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (WR_VALID) begin
          wrb_d   = 1'b0;
          din_d   = WR_DATA;
          waddr_d = addr_q;
          addr_d  = addr_q + 8'd1;
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - 8'd1;
        end
      end
      READ: begin
        if (rem_q != '0) begin
          rdb_d   = 1'b0;
          raddr_d = addr_q;
          addr_d  = addr_q + 8'd1;
          rem_d   = rem_q - 8'd1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // last issued word is in the RAM stage while vld_p0 is high
        if (!vld_p0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, working registers and registered RAM-side outputs.
  always_ff @(posedge CLKS) begin
    if (!RSTB) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dc_q    <= '0;
      wrb_q   <= 1'b1;
      rdb_q   <= 1'b1;
      din_q   <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dc_q    <= dc_d;
      wrb_q   <= wrb_d;
      rdb_q   <= rdb_d;
      din_q   <= din_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
    end
  end

  // Read return: track issued reads and their bank half, capture DO1/DO2.
  always_ff @(posedge CLKS) begin
    if (!RSTB) begin
      vld_p0     <= 1'b0;
      bsel_p0    <= 1'b0;
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      // p0: RAM is registering the read issued last cycle
      vld_p0  <= ~rdb_q;
      bsel_p0 <= dc_q[1];
      // p1: RAM output captured into RD_DATA
      vld_p1  <= vld_p0;
      if (vld_p0) rd_data_p1 <= bsel_p0 ? DO2 : DO1;
    end
  end

endmodule
